// File: rtl/multibyte_add_ctrl_pkg.sv
// Shared constants for the byte-serial adder: FSM state encoding and slice width.
package multibyte_add_ctrl_pkg;

  localparam int SLICE_W = 8;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

endpackage

// File: rtl/multibyte_add_ctrl_add8_ci.sv
// Combinational 8-bit adder slice with carry-in; also exposes the carry into bit 7
// so the controller can derive signed overflow of the most significant slice.
module add8_ci
  import multibyte_add_ctrl_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               cout,
  output logic               c7
);

  logic [SLICE_W:0]   w_sum;
  logic [SLICE_W-1:0] w_low;

  assign w_sum = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};
  assign w_low = {1'b0, a[SLICE_W-2:0]} + {1'b0, b[SLICE_W-2:0]} + {{(SLICE_W-1){1'b0}}, cin};

  assign s    = w_sum[SLICE_W-1:0];
  assign cout = w_sum[SLICE_W];
  assign c7   = w_low[SLICE_W-1];

endmodule

// File: rtl/multibyte_add_ctrl.sv
// Byte-serial wide add/subtract: one shared 8-bit slice walks the operands LSB byte
// first, rippling the carry through a register between cycles.
module multibyte_add_ctrl
  import multibyte_add_ctrl_pkg::*;
#(
  parameter int BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   sub,
  input  logic [SLICE_W*BYTES-1:0] op_a,
  input  logic [SLICE_W*BYTES-1:0] op_b,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [SLICE_W*BYTES-1:0] result,
  output logic                   cout,
  output logic                   ovf
);

  localparam int IDX_W = $clog2(BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic [1:0]                         r_state;
  logic [IDX_W-1:0]                   r_idx;
  logic                               r_carry;
  logic                               r_cout;
  logic                               r_ovf;
  logic [BYTES-1:0][SLICE_W-1:0]      r_a;
  logic [BYTES-1:0][SLICE_W-1:0]      r_b;
  logic [BYTES-1:0][SLICE_W-1:0]      r_result;

  logic [SLICE_W-1:0] w_s;
  logic               w_cout;
  logic               w_c7;
  logic               w_accept;

  assign w_accept = (r_state == S_IDLE) && start;

  add8_ci u_slice (
    .a    (r_a[r_idx]),
    .b    (r_b[r_idx]),
    .cin  (r_carry),
    .s    (w_s),
    .cout (w_cout),
    .c7   (w_c7)
  );

  // NOTE: operand registers carry no reset; every accepted start reloads them before use,
  // so a reset term would only add a mux in front of every bit.
  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_a <= op_a;
      r_b <= sub ? ~op_b : op_b;
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_carry  <= 1'b0;
      r_cout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_carry <= sub;
            r_idx   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_result[r_idx] <= w_s;
          r_carry         <= w_cout;
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_cout  <= w_cout;
            r_ovf   <= w_c7 ^ w_cout;
            r_state <= S_DONE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready  = (r_state == S_IDLE);
  assign busy   = (r_state == S_RUN);
  assign done   = (r_state == S_DONE);
  assign result = r_result;
  assign cout   = r_cout;
  assign ovf    = r_ovf;

endmodule

// File: tb/tb_multibyte_add_ctrl.sv
// Directed bench for multibyte_add_ctrl (BYTES=4): hand-computed sums, differences,
// overflow cases, ignored start during RUN, and reset mid-operation.
module tb_multibyte_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  multibyte_add_ctrl #(.BYTES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .sub    (sub),
    .op_a   (op_a),
    .op_b   (op_b),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .result (result),
    .cout   (cout),
    .ovf    (ovf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_tests++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Launch one operation, expect done exactly 4 edges after the start edge, check outputs.
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [31:0] exp_res,
                       input logic exp_cout, input logic exp_ovf);
    int lat;
    op_a  = a;
    op_b  = b;
    sub   = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    op_a  = 32'hDEAD_BEEF;
    op_b  = 32'h1357_9BDF;
    sub   = ~s;
    check({tag, " busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 12) begin
      tick();
      lat++;
    end
    check({tag, " latency"}, lat, 32'd4);
    check({tag, " result"}, result, exp_res);
    check({tag, " cout"}, {31'd0, cout}, {31'd0, exp_cout});
    check({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    check({tag, " ready@done"}, {31'd0, ready}, 32'd0);
    tick();
    check({tag, " done one-shot"}, {31'd0, done}, 32'd0);
    check({tag, " ready after"}, {31'd0, ready}, 32'd1);
    check({tag, " result held"}, result, exp_res);
  endtask

  initial begin
    int pulses;
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    op_a  = '0;
    op_b  = '0;
    tick();
    tick();
    rst = 1'b0;
    check("reset ready", {31'd0, ready}, 32'd1);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset result", result, 32'd0);
    check("reset cout", {31'd0, cout}, 32'd0);
    check("reset ovf", {31'd0, ovf}, 32'd0);

    do_op("c1 carry ripple", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
    do_op("c2 wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
    do_op("c3 signed ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    do_op("c4 5-7", 32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
    do_op("c4 7-5", 32'd7, 32'd5, 1'b1, 32'h0000_0002, 1'b1, 1'b0);

    // Start re-asserted with other operands during RUN must be ignored.
    op_a  = 32'h0000_00FF;
    op_b  = 32'h0000_0001;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    op_a = 32'h1234_5678;
    op_b = 32'h1111_1111;
    sub  = 1'b1;
    tick();
    check("c5 ready in run", {31'd0, ready}, 32'd0);
    tick();
    start  = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        check("c5 result", result, 32'h0000_0100);
        check("c5 ready@done", {31'd0, ready}, 32'd0);
      end
      tick();
    end
    check("c5 done pulses", pulses, 32'd1);

    // Reset at RUN idx=2 with start held high: partial result discarded, no done.
    op_a  = 32'h0102_0304;
    op_b  = 32'h0101_0101;
    sub   = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("c6 partial written", result, 32'h0000_0405);
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    check("c6 ready after rst", {31'd0, ready}, 32'd1);
    check("c6 busy after rst", {31'd0, busy}, 32'd0);
    check("c6 result cleared", result, 32'd0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) pulses++;
      tick();
    end
    check("c6 no activity", pulses, 32'd0);
    do_op("c6 after rst", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
